mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle control FSM for the MIPS core. Sequences the shared datapath (single memory port, one ALU, PC/IR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back steps. Supports R-type (incl. JR), ADDI, BNE, LW, SW and JAL. Tolerates variable memory latency through a ready handshake.

## Interface
Parameters:
- none (opcode/funct values come from the shared constants file)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, jal, sign_xtend  out  1 each  datapath strobes and selects
- alu_src_b  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- alu_op  out  3  010 add, 110 sub, 111 decode funct
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A
- illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP_R, JAL.
- Outputs are a Moore decode of state. Exceptions: pc_write and ir_write in FETCH are gated by mem_ready, and pc_write in BRANCH is qualified by !zero. Unlisted outputs are 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00.
  - When mem_ready: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=010, sign_xtend=1. Dispatch on opcode:
  - R_TYPE (000000): funct 001000 (JR) -> JUMP_R; other funct -> EXEC_R.
  - ADDI (001000) -> EXEC_I.
  - LW (100011) or SW (101011) -> MEM_ADDR.
  - BNE (000101) -> BRANCH.
  - JAL (000011) -> JAL.
  - Anything else -> FETCH with illegal_op=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111, sign_xtend=!funct[0]. Next WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0. Next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=010, sign_xtend=1. Next WB_I.
- WB_I: reg_dst=0, reg_write=1. Next FETCH.
- MEM_ADDR: same ALU settings as EXEC_I. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_source=01, pc_write=!zero. Next FETCH.
- JUMP_R: pc_source=11, pc_write=1. Next FETCH.
- JAL: pc_source=10, pc_write=1, reg_write=1, jal=1. Next FETCH.
- mem_read/mem_write stay asserted for every wait cycle. They are never both high.

## Timing
- Reset: asynchronous entry to IDLE, all outputs 0. First FETCH is 1 cycle after reset deasserts.
- Latency with mem_ready tied high:
  - BNE, JR, JAL: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is sampled only in those three states and ignored elsewhere.
- Reset mid-instruction: abandons the instruction. No write strobe is issued in the cycle after reset asserts.
- illegal_op asserts only in the DECODE cycle. It causes no register, memory or PC write.

## Structure
- Shared constants file mips_codes.sv holds:
  - opcode/funct codes;
  - alu_op encodings (ALU_ADD, ALU_SUB, ALU_FUNCT);
  - pc_source and alu_src_b encodings;
  - state enum mc_state_t.
- The existing single-cycle decoder uses the same opcode/alu_op constants.
- Single module, no sub-module: one state register, one next-state block, one output-decode block.

## Test plan
- ADDI with mem_ready=1 -> states FETCH, DECODE, EXEC_I, WB_I; reg_write=1 only in cycle 4, reg_dst=0; next FETCH in cycle 5.
- LW with FETCH delayed 2 cycles and MEM_RD delayed 3 cycles -> 10 cycles in total.
  - ir_write pulses exactly once, in the cycle mem_ready goes high.
  - mem_to_reg=1 with reg_write=1 only in WB_MEM.
- BNE with zero=1 -> pc_write stays 0 through BRANCH. With zero=0 -> pc_write=1 and pc_source=01 in cycle 3.
- JAL -> cycle 3 has pc_write=1, reg_write=1, jal=1, pc_source=10. R-type funct 001000 -> JUMP_R with pc_source=11, reg_write=0.
- Opcode 111111 -> illegal_op pulses once in DECODE, no write strobes, returns to FETCH.
- Assert reset during a stalled MEM_WR -> mem_write drops immediately, state IDLE, all outputs 0; FETCH one cycle after release.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared MIPS codes for the multicycle controller: opcode/funct values, ALU and
// mux-select encodings, the controller state enum and its output bundle.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REGA   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP_R, S_JAL
    } mc_state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       jal;
        logic       sign_xtend;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       busy;
    } mc_ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BNE) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, jal, sign_xtend;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       busy;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, jal, sign_xtend,
               alu_src_b, alu_op, pc_source, illegal_op, busy
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, jal, sign_xtend,
               alu_src_b, alu_op, pc_source, illegal_op, busy
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore output decode of state, with FETCH strobes
// gated by mem_ready, BNE's pc_write qualified by !zero, and illegal_op in DECODE.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);

    mc_state_t state_q, state_d;
    mc_ctrl_t  ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = (bus.funct == FN_JR) ? S_JUMP_R : S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BNE:       state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            // IR still holds the instruction, so the opcode picks load vs store here.
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP_R, S_JAL: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl      = '0;
        ctl.busy = (state_q != S_IDLE);
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_source = PC_SRC_ALU;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b  = SRCB_IMM_SH2;
                ctl.alu_op     = ALU_ADD;
                ctl.sign_xtend = 1'b1;
                ctl.illegal_op = !op_supported(bus.opcode);
            end
            S_EXEC_R: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_src_b  = SRCB_REG;
                ctl.alu_op     = ALU_FUNCT;
                ctl.sign_xtend = !bus.funct[0];
            end
            S_WB_R: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_src_b  = SRCB_IMM;
                ctl.alu_op     = ALU_ADD;
                ctl.sign_xtend = 1'b1;
            end
            S_WB_I:   ctl.reg_write = 1'b1;
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_source = PC_SRC_ALUOUT;
                ctl.pc_write  = !bus.zero;
            end
            S_JUMP_R: begin
                ctl.pc_source = PC_SRC_REGA;
                ctl.pc_write  = 1'b1;
            end
            S_JAL: begin
                ctl.pc_source = PC_SRC_JUMP;
                ctl.pc_write  = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.jal       = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_write   = ctl.pc_write;
    assign bus.ir_write   = ctl.ir_write;
    assign bus.i_or_d     = ctl.i_or_d;
    assign bus.mem_read   = ctl.mem_read;
    assign bus.mem_write  = ctl.mem_write;
    assign bus.mem_to_reg = ctl.mem_to_reg;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.jal        = ctl.jal;
    assign bus.sign_xtend = ctl.sign_xtend;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.pc_source  = ctl.pc_source;
    assign bus.illegal_op = ctl.illegal_op;
    assign bus.busy       = ctl.busy;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle controller: walks each instruction class
// cycle by cycle and compares the full control word and state to hand-computed values.
module tb_mips_multicycle_control;
    import mips_multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word order: pw iw iod mr mw m2r rd rw asa jal sx | asb | aop | psrc | ill | busy
    logic [19:0] ow;
    assign ow = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                 bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.jal,
                 bus.sign_xtend, bus.alu_src_b, bus.alu_op, bus.pc_source,
                 bus.illegal_op, bus.busy};

    localparam logic [19:0] E_IDLE     = 20'd0;
    localparam logic [19:0] E_FETCH_W  = {11'b00010000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_FETCH_R  = {11'b11010000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_DECODE   = {11'b00000000001, 2'b11, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_DEC_ILL  = {11'b00000000001, 2'b11, 3'b010, 2'b00, 1'b1, 1'b1};
    localparam logic [19:0] E_EXEC_R   = {11'b00000000101, 2'b00, 3'b111, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_EXEC_RU  = {11'b00000000100, 2'b00, 3'b111, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_WB_R     = {11'b00000011000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_EXEC_I   = {11'b00000000101, 2'b10, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_WB_I     = {11'b00000001000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_MEM_RD   = {11'b00110000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_WB_MEM   = {11'b00000101000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_MEM_WR   = {11'b00101000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1};
    localparam logic [19:0] E_BR_Z     = {11'b00000000100, 2'b00, 3'b110, 2'b01, 1'b0, 1'b1};
    localparam logic [19:0] E_BR_NZ    = {11'b10000000100, 2'b00, 3'b110, 2'b01, 1'b0, 1'b1};
    localparam logic [19:0] E_JR       = {11'b10000000000, 2'b00, 3'b000, 2'b11, 1'b0, 1'b1};
    localparam logic [19:0] E_JAL      = {11'b10000001010, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One controller cycle: sample mid-cycle, then move just past the next rising edge.
    task automatic cyc(input string tag, input logic [19:0] exp, input mc_state_t st);
        @(negedge clk);
        $display("%0t %s state=%0d word=%h", $time, tag, dut.state_q, ow);
        check_eq({tag, ".ctl"}, {12'd0, ow}, {12'd0, exp});
        check_eq({tag, ".st"}, {28'd0, 4'(dut.state_q)}, {28'd0, 4'(st)});
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        set_ins(6'd0, 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset.ctl", {12'd0, ow}, {12'd0, E_IDLE});
        check_eq("reset.st", {28'd0, 4'(dut.state_q)}, {28'd0, 4'(S_IDLE)});
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADDI, memory ready
        bus.mem_ready = 1'b1;
        set_ins(OP_ADDI, 6'b000101, 1'b0);
        cyc("addi.fetch", E_FETCH_R, S_FETCH);
        cyc("addi.decode", E_DECODE, S_DECODE);
        cyc("addi.exec", E_EXEC_I, S_EXEC_I);
        cyc("addi.wb", E_WB_I, S_WB_I);

        // LW: FETCH stalls 2 cycles, MEM_RD stalls 3 cycles -> 10 cycles
        set_ins(OP_LW, 6'd0, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("lw.fetch_w0", E_FETCH_W, S_FETCH);
        cyc("lw.fetch_w1", E_FETCH_W, S_FETCH);
        bus.mem_ready = 1'b1;
        cyc("lw.fetch", E_FETCH_R, S_FETCH);
        bus.mem_ready = 1'b0;
        cyc("lw.decode", E_DECODE, S_DECODE);
        cyc("lw.addr", E_EXEC_I, S_MEM_ADDR);
        for (int i = 0; i < 3; i++) cyc($sformatf("lw.rd_w%0d", i), E_MEM_RD, S_MEM_RD);
        bus.mem_ready = 1'b1;
        cyc("lw.rd", E_MEM_RD, S_MEM_RD);
        cyc("lw.wb", E_WB_MEM, S_WB_MEM);

        // SW, memory ready
        set_ins(OP_SW, 6'd0, 1'b0);
        cyc("sw.fetch", E_FETCH_R, S_FETCH);
        cyc("sw.decode", E_DECODE, S_DECODE);
        cyc("sw.addr", E_EXEC_I, S_MEM_ADDR);
        cyc("sw.wr", E_MEM_WR, S_MEM_WR);

        // BNE taken / not taken
        set_ins(OP_BNE, 6'd0, 1'b1);
        cyc("bne_z.fetch", E_FETCH_R, S_FETCH);
        cyc("bne_z.decode", E_DECODE, S_DECODE);
        cyc("bne_z.branch", E_BR_Z, S_BRANCH);
        set_ins(OP_BNE, 6'd0, 1'b0);
        cyc("bne_nz.fetch", E_FETCH_R, S_FETCH);
        cyc("bne_nz.decode", E_DECODE, S_DECODE);
        cyc("bne_nz.branch", E_BR_NZ, S_BRANCH);

        // JAL
        set_ins(OP_JAL, 6'b001000, 1'b0);
        cyc("jal.fetch", E_FETCH_R, S_FETCH);
        cyc("jal.decode", E_DECODE, S_DECODE);
        cyc("jal.jal", E_JAL, S_JAL);

        // R-type ADD (funct[0]=0) and ADDU (funct[0]=1)
        set_ins(OP_RTYPE, 6'b100000, 1'b0);
        cyc("add.fetch", E_FETCH_R, S_FETCH);
        cyc("add.decode", E_DECODE, S_DECODE);
        cyc("add.exec", E_EXEC_R, S_EXEC_R);
        cyc("add.wb", E_WB_R, S_WB_R);
        set_ins(OP_RTYPE, 6'b100001, 1'b0);
        cyc("addu.fetch", E_FETCH_R, S_FETCH);
        cyc("addu.decode", E_DECODE, S_DECODE);
        cyc("addu.exec", E_EXEC_RU, S_EXEC_R);
        cyc("addu.wb", E_WB_R, S_WB_R);

        // JR
        set_ins(OP_RTYPE, FN_JR, 1'b0);
        cyc("jr.fetch", E_FETCH_R, S_FETCH);
        cyc("jr.decode", E_DECODE, S_DECODE);
        cyc("jr.jump", E_JR, S_JUMP_R);

        // Illegal opcode returns straight to FETCH
        set_ins(6'b111111, 6'd0, 1'b0);
        cyc("ill.fetch", E_FETCH_R, S_FETCH);
        cyc("ill.decode", E_DEC_ILL, S_DECODE);

        // Reset during a stalled store
        set_ins(OP_SW, 6'd0, 1'b0);
        cyc("rst.fetch", E_FETCH_R, S_FETCH);
        cyc("rst.decode", E_DECODE, S_DECODE);
        cyc("rst.addr", E_EXEC_I, S_MEM_ADDR);
        bus.mem_ready = 1'b0;
        cyc("rst.wr_w0", E_MEM_WR, S_MEM_WR);
        @(negedge clk);
        check_eq("rst.wr_w1", {12'd0, ow}, {12'd0, E_MEM_WR});
        #2 reset = 1'b1;
        #1;
        check_eq("rst.async_ctl", {12'd0, ow}, {12'd0, E_IDLE});
        check_eq("rst.async_st", {28'd0, 4'(dut.state_q)}, {28'd0, 4'(S_IDLE)});
        @(posedge clk);
        #1;
        check_eq("rst.next_ctl", {12'd0, ow}, {12'd0, E_IDLE});
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("rst.idle", E_IDLE, S_IDLE);
        cyc("rst.refetch", E_FETCH_R, S_FETCH);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
